regfile_param: RTL

Parametrised multi-read-port register file with synchronous-reset clear sequencer, optional write-to-read bypass and a per-register pending-write scoreboard. It is the next-generation architectural register file for the RV32I core. It sits between decode (read ports, allocation), writeback (write port) and the hazard unit (pending flags).

---
 rtl/regfile_param_if.sv | 45 ++++
 rtl/regfile_param.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// ---------------------------------------------------------------------------
// regfile_param_if
// Bus bundle between the register file and its clients (decode read ports and
// allocation, writeback write port, hazard unit pending flags).
//
// Parameters must match those of the regfile_param instance it connects to.
//   rs_addr_i    NREAD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rs_data_o    NREAD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//   rs_pend_o    NREAD         pending-write flag per read port
//   rd_wren_i    1             write enable
//   rd_addr_i    ADDR_W        write address
//   rd_data_i    DATA_W        write data
//   alloc_i      1             mark alloc_addr_i as having an issued producer
//   alloc_addr_i ADDR_W        register to mark pending
//   ready_o      1             storage cleared, writes/allocs accepted
//
// Modports: master = client side, slave = register file side.
// ---------------------------------------------------------------------------
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2
);

   logic [NREAD*ADDR_W-1:0] rs_addr_i;
   logic [NREAD*DATA_W-1:0] rs_data_o;
   logic [NREAD-1:0]        rs_pend_o;
   logic                    rd_wren_i;
   logic [ADDR_W-1:0]       rd_addr_i;
   logic [DATA_W-1:0]       rd_data_i;
   logic                    alloc_i;
   logic [ADDR_W-1:0]       alloc_addr_i;
   logic                    ready_o;

   modport master (
      output rs_addr_i, rd_wren_i, rd_addr_i, rd_data_i, alloc_i, alloc_addr_i,
      input  rs_data_o, rs_pend_o, ready_o
   );

   modport slave (
      input  rs_addr_i, rd_wren_i, rd_addr_i, rd_data_i, alloc_i, alloc_addr_i,
      output rs_data_o, rs_pend_o, ready_o
   );

endinterface

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
// Parametrised multi-read-port architectural register file for the RV32I core.
// Register 0 is hardwired to zero and not stored. After reset a clear
// sequencer zeroes registers 1..DEPTH-1, one per cycle, before the file
// reports ready. A per-register pending bit tracks registers whose producer
// has been issued (alloc) but has not yet written back.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : same-cycle write data is forwarded to matching read ports and
//               the pending flag of that port is masked (unless a same-cycle
//               alloc targets the same register).
//   undefined : reads return stored contents only (read-before-write).
//
// Ports:
//   clk_i  clock, all state updates on the rising edge
//   rst_i  synchronous active-high reset
//   bus    regfile_param_if.slave (read ports, write port, alloc, ready)
//
// Parameters: DATA_W register width, ADDR_W address width (DEPTH = 2**ADDR_W),
//             NREAD number of read ports (1..4).
// ---------------------------------------------------------------------------
module regfile_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   regfile_param_if.slave   bus
);

   localparam int                DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q,   cnt_d;
   logic [DEPTH-1:0]  pend_q,  pend_d;

   logic [DATA_W-1:0] mem_q [1:DEPTH-1];

   logic              run;
   logic              wr_acc;
   logic              alloc_acc;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic [NREAD*DATA_W-1:0] rs_data_c;
   logic [NREAD-1:0]        rs_pend_c;
   logic [ADDR_W-1:0]       ra;

   // Writes and allocs only take effect once the clear has finished, and
   // register 0 can never be written nor become pending.
   always_comb begin
      run       = (state_q == ST_RUN);
      wr_acc    = run && bus.rd_wren_i && (bus.rd_addr_i != '0);
      alloc_acc = run && bus.alloc_i && (bus.alloc_addr_i != '0);
   end

   // Next-state logic: the INIT state owns the storage write port to sweep
   // zeros through every register; in RUN the port belongs to writeback.
   // The alloc update is applied after the write clear so a same-cycle
   // alloc and write to one register leaves it pending (new producer wins).
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      mem_we    = 1'b0;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      case (state_q)
         ST_INIT: begin
            mem_we    = (cnt_q != '0);
            mem_waddr = cnt_q;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_IDX) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (wr_acc) begin
               mem_we               = 1'b1;
               mem_waddr            = bus.rd_addr_i;
               mem_wdata            = bus.rd_data_i;
               pend_d[bus.rd_addr_i] = 1'b0;
            end
            if (alloc_acc) begin
               pend_d[bus.alloc_addr_i] = 1'b1;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
      pend_d[0] = 1'b0;
   end

   // Control state; reset restarts the clear from register 1 and forgets
   // every outstanding producer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_INIT;
         cnt_q   <= ADDR_W'(1);
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Storage array has no reset of its own; the clear sequencer zeroes it.
   always_ff @(posedge clk_i) begin
      if (!rst_i && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Combinational read ports. During INIT everything reads as zero so the
   // half-cleared array is never exposed.
   always_comb begin
      rs_data_c = '0;
      rs_pend_c = '0;
      ra        = '0;
      for (int k = 0; k < NREAD; k++) begin
         ra = bus.rs_addr_i[k*ADDR_W +: ADDR_W];
         if (run && (ra != '0)) begin
            rs_data_c[k*DATA_W +: DATA_W] = mem_q[ra];
            rs_pend_c[k]                  = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
            // Write-first forwarding: the value being written back this
            // cycle is already the architectural value for this reader.
            if (wr_acc && (bus.rd_addr_i == ra)) begin
               rs_data_c[k*DATA_W +: DATA_W] = bus.rd_data_i;
               if (!(alloc_acc && (bus.alloc_addr_i == ra))) begin
                  rs_pend_c[k] = 1'b0;
               end
            end
`endif
         end
      end
   end

   assign bus.rs_data_o = rs_data_c;
   assign bus.rs_pend_o = rs_pend_c;
   assign bus.ready_o   = run;

endmodule
